// File: rtl/filtro_decim.sv
// Streaming 7-tap fixed-coefficient filter with optional 2:1 decimation, rounding and saturation.
// Three lock-step stages (delay line, partial sums, final add) that all hold together under backpressure.
module filtro_decim #(
    parameter int DATA_WIDTH = 8,
    parameter bit ROUND      = 1'b0,
    parameter bit SAT        = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         decim_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH+1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH+1:0] out_data
);
    localparam int W  = DATA_WIDTH + 2;
    localparam int AW = DATA_WIDTH + 11;
    localparam logic signed [AW-1:0] RND  = AW'(ROUND ? 32 : 0);
    localparam logic signed [AW-1:0] MAXV = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = AW'(-(1 << (W - 1)));

    logic signed [W-1:0]  tap_reg [7];
    logic [2:0]           fill_reg;
    logic                 phase_reg;
    logic                 win_valid_reg;
    logic                 s1_valid_reg;
    logic signed [AW-1:0] grp_reg [3];

    logic                 stall;
    logic                 accept;
    logic                 emit;
    logic signed [AW-1:0] t [7];
    logic signed [AW-1:0] grp_next [3];
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] y;
    logic signed [W-1:0]  y_out;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~clear;
    assign accept   = in_valid & in_ready;
    // Only full windows are emitted; in decimation mode only those arriving on phase 0.
    assign emit     = accept & (fill_reg >= 3'd6) & (~decim_en | ~phase_reg);

    for (genvar gi = 0; gi < 7; gi++) begin : g_ext
        assign t[gi] = {{(AW - W){tap_reg[gi][W-1]}}, tap_reg[gi]};
    end

    // Coefficients 1,-5 | 17,58 | -10,4,-1 as shift-add; 58 = 64 - 4 - 2.
    always_comb begin
        grp_next[0] = t[0] - (t[1] <<< 2) - t[1];
        grp_next[1] = (t[2] <<< 4) + t[2] + (t[3] <<< 6) - (t[3] <<< 2) - (t[3] <<< 1);
        grp_next[2] = (t[5] <<< 2) - (t[4] <<< 3) - (t[4] <<< 1) - t[6];
    end

    always_comb begin
        sum = grp_reg[0] + grp_reg[1] + grp_reg[2] + RND;
        y   = sum >>> 6;
        if (SAT && (y > MAXV)) begin
            y_out = MAXV[W-1:0];
        end else if (SAT && (y < MINV)) begin
            y_out = MINV[W-1:0];
        end else begin
            y_out = y[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) tap_reg[i] <= '0;
            fill_reg      <= '0;
            phase_reg     <= 1'b0;
            win_valid_reg <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 7; i++) tap_reg[i] <= '0;
            fill_reg      <= '0;
            phase_reg     <= 1'b0;
            win_valid_reg <= 1'b0;
        end else if (!stall) begin
            win_valid_reg <= emit;
            if (accept) begin
                tap_reg[0] <= in_data;
                for (int i = 1; i < 7; i++) tap_reg[i] <= tap_reg[i-1];
                if (fill_reg != 3'd7) fill_reg <= fill_reg + 3'd1;
                phase_reg <= ~phase_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) grp_reg[i] <= '0;
            s1_valid_reg <= 1'b0;
        end else if (clear) begin
            s1_valid_reg <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < 3; i++) grp_reg[i] <= grp_next[i];
            s1_valid_reg <= win_valid_reg;
        end
    end

    // out_data only moves when a real result arrives, so it stays put across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) out_data <= y_out;
        end
    end
endmodule

// File: tb/tb_filtro_decim.sv
// Directed bench for filtro_decim: three parameter variants share one stimulus stream.
// Accepted outputs are collected per instance and compared against hand-computed values.
module tb_filtro_decim;
    localparam int DW = 8;
    localparam int W  = DW + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic decim_en = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [W-1:0] in_data = '0;

    logic in_ready, in_ready_r, in_ready_w;
    logic out_valid, out_valid_r, out_valid_w;
    logic signed [W-1:0] out_data, out_data_r, out_data_w;

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] q0[$];
    logic signed [W-1:0] q1[$];
    logic signed [W-1:0] q2[$];
    int exp_q[$];

    always #5 clk = ~clk;

    filtro_decim #(.DATA_WIDTH(DW), .ROUND(1'b0), .SAT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .decim_en(decim_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    filtro_decim #(.DATA_WIDTH(DW), .ROUND(1'b1), .SAT(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .clear(clear), .decim_en(decim_en),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r)
    );

    filtro_decim #(.DATA_WIDTH(DW), .ROUND(1'b0), .SAT(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear), .decim_en(decim_en),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w)
    );

    always @(negedge clk) begin
        if (rst_n && !clear && out_ready) begin
            if (out_valid)   q0.push_back(out_data);
            if (out_valid_r) q1.push_back(out_data_r);
            if (out_valid_w) q2.push_back(out_data_w);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        $display("check %s: observed %0d expected %0d", tag, obs, expv);
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input int d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = W'(d);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            step();
        end
        check("accept", done, 1);
    endtask

    task automatic clr();
        in_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic check_q(input string tag, input int sel);
        logic signed [W-1:0] got[$];
        case (sel)
            0:       got = q0;
            1:       got = q1;
            default: got = q2;
        endcase
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    endtask

    task automatic wait_valid(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else step();
        end
        check(tag, found, 1);
    endtask

    initial begin
        int imp[8] = '{0, 1, -5, 17, 58, -10, 4, -1};
        int sat_seq[7] = '{-512, 511, -512, 511, 511, -512, 511};
        logic signed [W-1:0] held;

        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // DC and first-output latency
        for (int pass = 0; pass < 2; pass++) begin
            int v;
            v = (pass == 0) ? 100 : -100;
            decim_en = 1'b0;
            clr();
            for (int i = 0; i < 6; i++) send(v);
            send(v);
            in_valid = 1'b0;
            check("dc_lat_k", out_valid, 0);
            step();
            check("dc_lat_k1", out_valid, 0);
            step();
            check("dc_lat_k2", out_valid, 1);
            check("dc_lat_data", out_data, v);
            for (int i = 0; i < 5; i++) send(v);
            idle(4);
            exp_q.delete();
            for (int i = 0; i < 6; i++) exp_q.push_back(v);
            check_q("dc", 0);
        end

        // Impulse response
        clr();
        for (int i = 0; i < 7; i++) send(0);
        send(64);
        for (int i = 0; i < 6; i++) send(0);
        idle(4);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(imp[i]);
        check_q("impulse", 0);

        // Saturation versus wrap
        clr();
        for (int i = 0; i < 7; i++) send(sat_seq[i]);
        idle(4);
        exp_q.delete(); exp_q.push_back(511);
        check_q("sat_clamp", 0);
        exp_q.delete(); exp_q.push_back(-258);
        check_q("sat_wrap", 2);

        // Rounding, positive then negative
        clr();
        for (int i = 0; i < 6; i++) send(0);
        send(32);
        idle(4);
        exp_q.delete(); exp_q.push_back(0);
        check_q("rnd_p_trunc", 0);
        exp_q.delete(); exp_q.push_back(1);
        check_q("rnd_p_round", 1);
        clr();
        for (int i = 0; i < 6; i++) send(0);
        send(-32);
        idle(4);
        exp_q.delete(); exp_q.push_back(-1);
        check_q("rnd_n_trunc", 0);
        exp_q.delete(); exp_q.push_back(0);
        check_q("rnd_n_round", 1);

        // Decimation with a mid-stream stall; ramp n gives n-3 per window
        decim_en = 1'b1;
        clr();
        for (int i = 0; i < 10; i++) send(i);
        in_valid = 1'b0;
        wait_valid("bp_wait");
        out_ready = 1'b0;
        held = out_data;
        in_valid = 1'b1;
        in_data = W'(10);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", out_data, held);
            check("bp_valid", out_valid, 1);
        end
        step();
        out_ready = 1'b1;
        for (int i = 10; i < 20; i++) send(i);
        idle(6);
        exp_q.delete();
        for (int n = 6; n <= 18; n += 2) exp_q.push_back(n - 3);
        check_q("decim", 0);

        // Flush while an output is pending
        decim_en = 1'b0;
        clr();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(20);
        in_valid = 1'b0;
        wait_valid("clr_wait");
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = W'(77);
        @(negedge clk);
        check("clr_in_ready", in_ready, 0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", out_valid, 0);
        out_ready = 1'b1;
        exp_q.delete();
        check_q("clr_flush", 0);
        for (int i = 0; i < 6; i++) send(20);
        in_valid = 1'b0;
        repeat (3) begin
            step();
            check("clr_warm_none", out_valid, 0);
        end
        send(20);
        in_valid = 1'b0;
        step();
        step();
        check("clr_7th_valid", out_valid, 1);
        check("clr_7th_data", out_data, 20);
        idle(2);

        // Asynchronous reset mid-stream
        clr();
        for (int i = 0; i < 8; i++) send(30);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        q0.delete();
        for (int i = 0; i < 6; i++) send(40);
        in_valid = 1'b0;
        repeat (3) begin
            step();
            check("arst_warm_none", out_valid, 0);
        end
        send(40);
        in_valid = 1'b0;
        step();
        step();
        check("arst_7th_valid", out_valid, 1);
        check("arst_7th_data", out_data, 40);
        idle(3);
        exp_q.delete(); exp_q.push_back(40);
        check_q("arst_out", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
